// File: rtl/uart_instr_buffer.sv
// UART-loaded 256-byte instruction buffer (device id 3): bytes arrive over 8N1 serial, fetches return registered words.
// Define UART_PARITY_EN to switch the receiver to 8E1 with parity checking.
module uart_instr_buffer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic [2:0]  instr_device,
  input  logic [7:0]  instr_addr_local,
  output logic [31:0] instr_data,
  output logic        instr_valid,
  output logic        load_busy,
  output logic        load_done,
  output logic        frame_error
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [2:0]  MY_DEVICE = 3'd3;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_sync;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      wr_ptr;
  logic            par_err;
  logic            tick;
  logic            accept;
  logic [7:0]      mem [DEPTH];

  logic [5:0]      word_idx;
  logic            word_loaded;
  logic [31:0]     fetch_word;
  logic            fetch_req;
  logic            unused_addr_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick   = (clk_cnt == BIT_LAST);
  // Bytes arriving after the buffer filled are silently discarded.
  assign accept = (state == S_STOP) && tick && rx_sync && !par_err && !load_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      wr_ptr      <= '0;
      load_done   <= 1'b0;
      load_busy   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state     <= S_START;
            clk_cnt   <= '0;
            load_busy <= 1'b1;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!rx_sync) begin
              state <= S_DATA;
            end else begin
              state     <= S_IDLE;
              load_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            clk_cnt <= '0;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              frame_error <= 1'b1;
              state       <= S_WAIT_IDLE;
            end else begin
              frame_error <= par_err;
              state       <= S_IDLE;
              load_busy   <= 1'b0;
              if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == 8'hFF) begin
                  load_done <= 1'b1;
                end
              end
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync) begin
            state     <= S_IDLE;
            load_busy <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if (state == S_START) begin
      par_err <= 1'b0;
    end else if (state == S_PARITY && tick) begin
      par_err <= (rx_sync != ^shreg);
    end
  end
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // Reads see pre-write RAM and wr_ptr, so a word completing this cycle still returns NOP.
  assign word_idx         = instr_addr_local[7:2];
  assign unused_addr_bits = ^instr_addr_local[1:0];
  assign word_loaded      = load_done || (word_idx < wr_ptr[7:2]);
  assign fetch_req        = (instr_device == MY_DEVICE);
  assign fetch_word       = {mem[{word_idx, 2'b11}], mem[{word_idx, 2'b10}],
                             mem[{word_idx, 2'b01}], mem[{word_idx, 2'b00}]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr_data  <= '0;
    end else begin
      instr_valid <= fetch_req;
      if (fetch_req) begin
        instr_data <= word_loaded ? fetch_word : NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_uart_instr_buffer.sv
// Scoreboard bench for uart_instr_buffer: fetch expectations are queued at request time and popped by a monitor.
`timescale 1ns/1ps
module tb_uart_instr_buffer;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic [2:0]  instr_device = 3'd0;
  logic [7:0]  instr_addr_local = 8'd0;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        load_busy;
  logic        load_done;
  logic        frame_error;

  int checks = 0;
  int passes = 0;
  int fe_cycles = 0;
  int fe_before = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  uart_instr_buffer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(256)) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .instr_device(instr_device),
    .instr_addr_local(instr_addr_local),
    .instr_data(instr_data),
    .instr_valid(instr_valid),
    .load_busy(load_busy),
    .load_done(load_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Monitor: every valid response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_error) fe_cycles++;
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected instr_valid", {31'd0, instr_valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("fetch data", instr_data, mon_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] exp);
    instr_device     = 3'd3;
    instr_addr_local = addr;
    exp_q.push_back(exp);
    tick(1);
  endtask

  task automatic idleBus();
    instr_device = 3'd0;
    tick(2);
    checkOutput("response queue drained", exp_q.size(), 32'd0);
  endtask

  task automatic driveBit(input logic b);
    uart_rx = b;
    tick(DIV);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop_bit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_PARITY_EN
    driveBit(^d);
`endif
    driveBit(stop_bit);
  endtask

  task automatic sendByte(input logic [7:0] d);
    sendFrame(d, 1'b1);
    uart_rx = 1'b1;
    tick(3);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    checkOutput({tag, " instr_data"}, instr_data, 32'd0);
    checkOutput({tag, " load_busy"}, {31'd0, load_busy}, 32'd0);
    checkOutput({tag, " load_done"}, {31'd0, load_done}, 32'd0);
    checkOutput({tag, " frame_error"}, {31'd0, frame_error}, 32'd0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

`ifdef UART_PARITY_EN
  task automatic sendFrameParity(input logic [7:0] d, input logic par_bit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    driveBit(par_bit);
    driveBit(1'b1);
    uart_rx = 1'b1;
    tick(3);
  endtask
`endif

  initial begin
    checkResetOutputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(2);

    applyStimulus(8'h00, NOP);
    idleBus();

    // Basic load of one NOP word
    sendByte(8'h13); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    checkOutput("load_busy after byte", {31'd0, load_busy}, 32'd0);
    applyStimulus(8'h00, 32'h0000_0013);
    applyStimulus(8'h04, NOP);
    idleBus();
    checkOutput("instr_data hold", instr_data, NOP);

    instr_device = 3'd2; tick(3);
    instr_device = 3'd7; tick(1);
    idleBus();

    sendByte(8'hEF); sendByte(8'hBE); sendByte(8'hAD); sendByte(8'hDE);
    applyStimulus(8'h06, 32'hDEAD_BEEF);
    applyStimulus(8'h08, NOP);
    applyStimulus(8'h03, 32'h0000_0013);
    idleBus();

    // Short low glitch must not start a byte or raise an error
    fe_before = fe_cycles;
    uart_rx = 1'b0; tick(2);
    uart_rx = 1'b1; tick(20);
    checkOutput("glitch load_busy", {31'd0, load_busy}, 32'd0);
    checkOutput("glitch frame_error", fe_cycles - fe_before, 32'd0);

    sendByte(8'h55);
    applyStimulus(8'h08, NOP);
    idleBus();

    // Bad stop bit, line held low afterwards
    fe_before = fe_cycles;
    sendFrame(8'hAA, 1'b0);
    uart_rx = 1'b0;
    tick(20);
    checkOutput("wait_idle load_busy", {31'd0, load_busy}, 32'd1);
    checkOutput("frame_error pulse cycles", fe_cycles - fe_before, 32'd1);
    uart_rx = 1'b1;
    tick(10);
    checkOutput("after error load_busy", {31'd0, load_busy}, 32'd0);
    sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
    applyStimulus(8'h08, 32'h8877_6655);
    idleBus();

    // Fill the whole buffer from empty
    applyReset();
    for (int i = 0; i < 255; i++) sendByte(8'(i));
    checkOutput("load_done at 255", {31'd0, load_done}, 32'd0);
    applyStimulus(8'hFC, NOP);
    idleBus();
    sendByte(8'hFF);
    checkOutput("load_done at 256", {31'd0, load_done}, 32'd1);
    applyStimulus(8'hFC, 32'hFFFE_FDFC);
    applyStimulus(8'h00, 32'h0302_0100);
    idleBus();
    sendByte(8'hAA);
    applyStimulus(8'h00, 32'h0302_0100);
    applyStimulus(8'h10, 32'h1312_1110);
    idleBus();
    checkOutput("load_done sticky", {31'd0, load_done}, 32'd1);

    // Reset in the middle of a data bit
    driveBit(1'b0);
    driveBit(1'b1); driveBit(1'b0); driveBit(1'b1);
    tick(3);
    reset = 1'b1;
    uart_rx = 1'b1;
    checkResetOutputs("mid-frame reset");
    @(posedge clk);
    #1 reset = 1'b0;
    tick(3);
    applyStimulus(8'h00, NOP);
    idleBus();
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    applyStimulus(8'h00, 32'h4433_2211);
    idleBus();

`ifdef UART_PARITY_EN
    fe_before = fe_cycles;
    sendFrameParity(8'h01, 1'b0);
    checkOutput("parity error pulse", fe_cycles - fe_before, 32'd1);
    sendFrameParity(8'h01, 1'b1);
    checkOutput("good parity no error", fe_cycles - fe_before, 32'd1);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    applyStimulus(8'h04, 32'h0403_0201);
    idleBus();
`endif

    checkOutput("final queue empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
